// File: rtl/nn_pkg.sv
// Shared types and constants for the layer sequencer and its descriptor table.
package nn_pkg;

    localparam int unsigned DIM_W  = 10;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StNext,
        StDone,
        StError
    } seq_state_e;

    typedef struct packed {
        logic [DIM_W-1:0]  m;
        logic [DIM_W-1:0]  n;
        logic [DIM_W-1:0]  k;
        logic [ADDR_W-1:0] w_base;
    } layer_desc_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Command/done link between the layer sequencer (master) and the matmul engine (slave).
interface layer_sequencer_if;
    import nn_pkg::*;

    logic              mm_start;
    logic [DIM_W-1:0]  mm_m;
    logic [DIM_W-1:0]  mm_n;
    logic [DIM_W-1:0]  mm_k;
    logic [ADDR_W-1:0] mm_in_base;
    logic [ADDR_W-1:0] mm_w_base;
    logic [ADDR_W-1:0] mm_out_base;
    logic              mm_done;

    modport master (
        output mm_start, mm_m, mm_n, mm_k, mm_in_base, mm_w_base, mm_out_base,
        input  mm_done
    );

    modport slave (
        input  mm_start, mm_m, mm_n, mm_k, mm_in_base, mm_w_base, mm_out_base,
        output mm_done
    );

endinterface

// File: rtl/layer_desc_table.sv
// Per-layer descriptor register file: one write port, asynchronous read port.
// Contents are deliberately not reset; software programs the table before use.
module layer_desc_table
    import nn_pkg::*;
#(
    parameter int unsigned MAX_LAYERS = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  layer_desc_t      wdata,
    input  logic [IDX_W-1:0] raddr,
    output layer_desc_t      rdata
);

    layer_desc_t mem_q [MAX_LAYERS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/layer_sequencer.sv
// Runs a stack of fully-connected layers through one matmul engine, ping-ponging
// activations between regions A and B. Optional watchdog: LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned       MAX_LAYERS = 8,
    parameter int unsigned       IDX_W      = 3,
    parameter logic [ADDR_W-1:0] BUF_A_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] BUF_B_BASE = 16'h4000
`ifdef LAYER_SEQ_TIMEOUT_EN
    , parameter int unsigned     TIMEOUT_CYCLES = 1048576
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [DIM_W-1:0]   cfg_m,
    input  logic [DIM_W-1:0]   cfg_n,
    input  logic [DIM_W-1:0]   cfg_k,
    input  logic [ADDR_W-1:0]  cfg_w_base,
    input  logic [IDX_W:0]     num_layers,
    input  logic               run_start,
    output logic               run_busy,
    output logic               run_done,
    output logic               run_err,
    output logic [IDX_W-1:0]   cur_layer,
    output logic [ADDR_W-1:0]  final_base,
    layer_sequencer_if.master  mm
);

    localparam logic [IDX_W:0] MaxCount = (IDX_W+1)'(MAX_LAYERS);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cur_layer_q, cur_layer_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              parity_q, parity_d;
    logic              run_err_q, run_err_d;
    logic [ADDR_W-1:0] final_base_q, final_base_d;
    logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d, w_base_q, w_base_d, out_base_q, out_base_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
    logic [31:0]       tmo_q, tmo_d;
`endif

    layer_desc_t wr_desc, rd_desc;
    logic        count_ok;

    assign run_busy = (state_q == StLoad) || (state_q == StStart) ||
                      (state_q == StWait) || (state_q == StNext);
    assign count_ok = (num_layers != '0) && (num_layers <= MaxCount);
    assign wr_desc  = '{m: cfg_m, n: cfg_n, k: cfg_k, w_base: cfg_w_base};

    layer_desc_table #(
        .MAX_LAYERS (MAX_LAYERS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we & ~run_busy),
        .waddr (cfg_idx),
        .wdata (wr_desc),
        .raddr (cur_layer_q),
        .rdata (rd_desc)
    );

    // Next-state and register updates for the layer walk
    always_comb begin
        state_d      = state_q;
        cur_layer_d  = cur_layer_q;
        count_d      = count_q;
        parity_d     = parity_q;
        run_err_d    = run_err_q;
        final_base_d = final_base_q;
        m_d          = m_q;
        n_d          = n_q;
        k_d          = k_q;
        in_base_d    = in_base_q;
        w_base_d     = w_base_q;
        out_base_d   = out_base_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (run_start) begin
                    if (count_ok) begin
                        state_d      = StLoad;
                        count_d      = num_layers;
                        cur_layer_d  = '0;
                        parity_d     = 1'b0;
                        run_err_d    = 1'b0;
                        // Odd layer counts end with the result in B, even in A
                        final_base_d = num_layers[0] ? BUF_B_BASE : BUF_A_BASE;
                    end else begin
                        run_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (rd_desc.m == '0 || rd_desc.n == '0 || rd_desc.k == '0) begin
                    state_d   = StError;
                    run_err_d = 1'b1;
                end else begin
                    state_d    = StStart;
                    m_d        = rd_desc.m;
                    n_d        = rd_desc.n;
                    k_d        = rd_desc.k;
                    w_base_d   = rd_desc.w_base;
                    in_base_d  = parity_q ? BUF_B_BASE : BUF_A_BASE;
                    out_base_d = parity_q ? BUF_A_BASE : BUF_B_BASE;
                end
            end
            StStart: begin
                state_d = StWait;
`ifdef LAYER_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            StWait: begin
                // Engine drops done on the edge that samples mm_start, so no stale done here
                if (mm.mm_done) begin
                    state_d = StNext;
                end
`ifdef LAYER_SEQ_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                    state_d   = StError;
                    run_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            StNext: begin
                if ({1'b0, cur_layer_q} == count_q - 1'b1) begin
                    state_d = StDone;
                end else begin
                    state_d     = StLoad;
                    cur_layer_d = cur_layer_q + 1'b1;
                    parity_d    = ~parity_q;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_layer_q  <= '0;
            count_q      <= '0;
            parity_q     <= 1'b0;
            run_err_q    <= 1'b0;
            final_base_q <= '0;
            m_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            in_base_q    <= '0;
            w_base_q     <= '0;
            out_base_q   <= '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_layer_q  <= cur_layer_d;
            count_q      <= count_d;
            parity_q     <= parity_d;
            run_err_q    <= run_err_d;
            final_base_q <= final_base_d;
            m_q          <= m_d;
            n_q          <= n_d;
            k_q          <= k_d;
            in_base_q    <= in_base_d;
            w_base_q     <= w_base_d;
            out_base_q   <= out_base_d;
`ifdef LAYER_SEQ_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign run_done       = (state_q == StDone);
    assign run_err        = run_err_q;
    assign cur_layer      = cur_layer_q;
    assign final_base     = final_base_q;
    assign mm.mm_start    = (state_q == StStart);
    assign mm.mm_m        = m_q;
    assign mm.mm_n        = n_q;
    assign mm.mm_k        = k_q;
    assign mm.mm_in_base  = in_base_q;
    assign mm.mm_w_base   = w_base_q;
    assign mm.mm_out_base = out_base_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised self-checking bench for layer_sequencer with a behavioural engine model.
module tb_layer_sequencer;

    localparam int BUF_A = 32'h0000;
    localparam int BUF_B = 32'h4000;

    typedef struct {
        int m, n, k, w, in_b, out_b;
    } start_rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [9:0]  cfg_m, cfg_n, cfg_k;
    logic [15:0] cfg_w_base;
    logic [3:0]  num_layers;
    logic        run_start;
    logic        run_busy, run_done, run_err;
    logic [2:0]  cur_layer;
    logic [15:0] final_base;

    layer_sequencer_if mm_bus ();

    layer_sequencer #(
        .MAX_LAYERS (8),
        .IDX_W      (3),
        .BUF_A_BASE (16'h0000),
        .BUF_B_BASE (16'h4000)
`ifdef LAYER_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_m      (cfg_m),
        .cfg_n      (cfg_n),
        .cfg_k      (cfg_k),
        .cfg_w_base (cfg_w_base),
        .num_layers (num_layers),
        .run_start  (run_start),
        .run_busy   (run_busy),
        .run_done   (run_done),
        .run_err    (run_err),
        .cur_layer  (cur_layer),
        .final_base (final_base),
        .mm         (mm_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference descriptor table
    int ref_m [8];
    int ref_n [8];
    int ref_k [8];
    int ref_w [8];

    // Engine model knobs
    int lat_min = 1;
    int lat_max = 4;
    bit hang = 1'b0;
    int eng_cnt;

    // Monitor observations
    start_rec_t starts [$];
    int done_seen = 0, busy_cnt = 0, unstable_cnt = 0;
    int fb_at_done = 0;
    int q_base, done_base, busy_base, unst_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Engine: done drops on the edge that sees mm_start, rises after a random latency
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_bus.mm_done <= 1'b0;
            eng_cnt        <= 0;
        end else if (mm_bus.mm_start) begin
            mm_bus.mm_done <= 1'b0;
            eng_cnt        <= hang ? 0 : int'($urandom_range(lat_max, lat_min));
        end else if (eng_cnt == 1) begin
            mm_bus.mm_done <= 1'b1;
            eng_cnt        <= 0;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Observe starts, completions, busy and command stability while the engine works
    always @(negedge clk) begin
        if (rst_n) begin
            if (mm_bus.mm_start) begin
                starts.push_back('{m: int'(mm_bus.mm_m), n: int'(mm_bus.mm_n),
                                   k: int'(mm_bus.mm_k), w: int'(mm_bus.mm_w_base),
                                   in_b: int'(mm_bus.mm_in_base),
                                   out_b: int'(mm_bus.mm_out_base)});
            end
            if (run_done) begin
                done_seen  <= done_seen + 1;
                fb_at_done <= int'(final_base);
            end
            if (run_busy) busy_cnt <= busy_cnt + 1;
            if (eng_cnt > 0 && starts.size() > 0) begin
                if (int'(mm_bus.mm_m) != starts[$].m || int'(mm_bus.mm_n) != starts[$].n ||
                    int'(mm_bus.mm_k) != starts[$].k || int'(mm_bus.mm_w_base) != starts[$].w ||
                    int'(mm_bus.mm_in_base) != starts[$].in_b ||
                    int'(mm_bus.mm_out_base) != starts[$].out_b)
                    unstable_cnt <= unstable_cnt + 1;
            end
        end
    end

    task automatic program_desc(input int idx, input int m, input int n, input int k,
                                input int w);
        cfg_idx    = 3'(idx);
        cfg_m      = 10'(m);
        cfg_n      = 10'(n);
        cfg_k      = 10'(k);
        cfg_w_base = 16'(w);
        cfg_we     = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
        ref_m[idx] = m;
        ref_n[idx] = n;
        ref_k[idx] = k;
        ref_w[idx] = w;
    endtask

    task automatic launch(input int cnt);
        q_base     = starts.size();
        done_base  = done_seen;
        busy_base  = busy_cnt;
        unst_base  = unstable_cnt;
        num_layers = 4'(cnt);
        run_start  = 1'b1;
        @(negedge clk);
        run_start  = 1'b0;
    endtask

    task automatic wait_end();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_seen != done_base || run_err) break;
        end
        check("run_ends", 32'(i < 3000), 1);
        repeat (3) @(negedge clk);
    endtask

    // Expected outcome derived from the table contents and the layer count
    task automatic check_run(input int cnt);
        bit valid, ok;
        int zero_at, exp_n, got_n;
        start_rec_t r;
        valid   = (cnt >= 1) && (cnt <= 8);
        zero_at = cnt;
        if (valid) begin
            for (int i = 0; i < cnt; i++) begin
                if (ref_m[i] == 0 || ref_n[i] == 0 || ref_k[i] == 0) begin
                    zero_at = i;
                    break;
                end
            end
        end
        exp_n = valid ? zero_at : 0;
        ok    = valid && (zero_at == cnt);
        got_n = starts.size() - q_base;
        check("n_starts", got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            r = starts[q_base + i];
            check("mm_m", r.m, ref_m[i]);
            check("mm_n", r.n, ref_n[i]);
            check("mm_k", r.k, ref_k[i]);
            check("mm_w_base", r.w, ref_w[i]);
            check("mm_in_base", r.in_b, (i % 2 == 0) ? BUF_A : BUF_B);
            check("mm_out_base", r.out_b, (i % 2 == 0) ? BUF_B : BUF_A);
        end
        check("run_done_cnt", done_seen - done_base, ok ? 1 : 0);
        if (ok) check("final_base", fb_at_done, (cnt % 2 == 1) ? BUF_B : BUF_A);
        check("run_err", 32'(run_err), 32'(!ok));
        check("run_busy_idle", 32'(run_busy), 0);
        check("busy_seen", 32'(busy_cnt != busy_base), 32'(valid));
        check("mm_stable", unstable_cnt - unst_base, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(run_busy), 0);
        check({tag, "_done"}, 32'(run_done), 0);
        check({tag, "_err"}, 32'(run_err), 0);
        check({tag, "_cur"}, 32'(cur_layer), 0);
        check({tag, "_final"}, 32'(final_base), 0);
        check({tag, "_start"}, 32'(mm_bus.mm_start), 0);
        check({tag, "_dims"}, {mm_bus.mm_m, mm_bus.mm_n, mm_bus.mm_k}, 0);
        check({tag, "_bases"}, {mm_bus.mm_in_base, mm_bus.mm_out_base}, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
        cfg_w_base = '0; num_layers = '0; run_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Two layers with the documented shapes
        program_desc(0, 4, 2, 3, 16'h1000);
        program_desc(1, 4, 5, 2, 16'h2000);
        launch(2);
        check("load_no_start", 32'(mm_bus.mm_start), 0);
        @(negedge clk);
        check("start_cycle", 32'(mm_bus.mm_start), 1);
        wait_end();
        check_run(2);

        // Out-of-range counts
        launch(0);
        wait_end();
        check_run(0);
        launch(9);
        wait_end();
        check_run(9);

        // Zero k on layer 1, then a valid run clears the error
        program_desc(1, 4, 5, 0, 16'h2000);
        launch(2);
        wait_end();
        check_run(2);
        program_desc(1, 4, 5, 2, 16'h2000);
        launch(2);
        wait_end();
        check_run(2);

        // Writes and restarts while waiting on the engine are dropped
        program_desc(2, 9, 8, 7, 16'h3000);
        lat_min = 20; lat_max = 20;
        launch(3);
        repeat (6) @(negedge clk);
        cfg_idx = 3'd0; cfg_m = 10'd99; cfg_n = 10'd98; cfg_k = 10'd97;
        cfg_w_base = 16'hBEEF; cfg_we = 1'b1; num_layers = 4'd1; run_start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; run_start = 1'b0;
        wait_end();
        check_run(3);
        launch(3);
        wait_end();
        check_run(3);

        // Reset in the middle of WAIT
        launch(3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat_min = 1; lat_max = 6;
        launch(3);
        wait_end();
        check_run(3);

        // Random tables, counts and engine latencies
        for (int it = 0; it < 25; it++) begin
            for (int d = 0; d < 8; d++) begin
                int m, n, k;
                m = int'($urandom_range(1023, 1));
                n = int'($urandom_range(1023, 1));
                k = int'($urandom_range(1023, 1));
                if ($urandom_range(23, 0) == 0) m = 0;
                if ($urandom_range(23, 0) == 0) n = 0;
                if ($urandom_range(23, 0) == 0) k = 0;
                program_desc(d, m, n, k, int'($urandom_range(16'hFFFF, 0)));
            end
            launch(int'($urandom_range(9, 0)));
            wait_end();
            check_run(int'(num_layers));
        end

`ifdef LAYER_SEQ_TIMEOUT_EN
        begin
            int i, n;
            program_desc(0, 3, 3, 3, 16'h0100);
            hang = 1'b1;
            launch(1);
            for (i = 0; i < 10 && !mm_bus.mm_start; i++) @(negedge clk);
            check("tmo_start", 32'(mm_bus.mm_start), 1);
            for (n = 0; n < 100; n++) begin
                @(negedge clk);
                if (run_err) break;
            end
            check("tmo_cycles", n + 1, 17);
            repeat (2) @(negedge clk);
            check("tmo_n_starts", starts.size() - q_base, 1);
            check("tmo_err", 32'(run_err), 1);
            check("tmo_idle", 32'(run_busy), 0);
            hang = 1'b0;
            launch(1);
            wait_end();
            check_run(1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
